// File: rtl/fetch_exec_sequencer.sv
// Fetch/decode/execute control sequencer for the 8-bit accumulator CPU.
// Drives the instruction-memory handshake and the datapath strobes, and counts retired instructions.
module fetch_exec_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             CLB,
  input  logic [7:0]       Opcode,
  input  logic             Z,
  input  logic             C,
  input  logic             MemAck,
  output logic             MemReq,
  output logic             LoadIR,
  output logic             IncPC,
  output logic             SelPC,
  output logic             LoadPC,
  output logic             LoadReg,
  output logic             LoadAcc,
  output logic [1:0]       SelAcc,
  output logic [3:0]       SelALU,
  output logic             Halted,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_IMM    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_NOR  = 4'h3;
  localparam logic [3:0] OP_MOVR = 4'h4;
  localparam logic [3:0] OP_MOVA = 4'h5;
  localparam logic [3:0] OP_JZR  = 4'h6;
  localparam logic [3:0] OP_JZI  = 4'h7;
  localparam logic [3:0] OP_JCR  = 4'h8;
  localparam logic [3:0] OP_JCI  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ACC_ALU  = 2'b10;
  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire_s;
  logic             imm_flag_s;
  logic [3:0]       op_s;
  logic             unused_reg_idx_s;

  // The low nibble selects a register in the regfile and plays no part in sequencing.
  assign op_s             = Opcode[7:4];
  assign unused_reg_idx_s = ^Opcode[3:0];
  assign imm_flag_s       = (op_s == OP_JZI) ? Z : C;
  assign InstrCount       = cnt_q;

  // State and retired-instruction counter registers
  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and Mealy strobe decode
  always_comb begin
    state_d  = state_q;
    retire_s = 1'b0;
    MemReq   = 1'b0;
    LoadIR   = 1'b0;
    IncPC    = 1'b0;
    SelPC    = 1'b0;
    LoadPC   = 1'b0;
    LoadReg  = 1'b0;
    LoadAcc  = 1'b0;
    SelAcc   = 2'b00;
    SelALU   = 4'b0000;
    Halted   = 1'b0;
    Illegal  = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        MemReq = 1'b1;
        if (MemAck) begin
          LoadIR  = 1'b1;
          IncPC   = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_DECODE: begin
        case (op_s)
          OP_NOP, OP_ADD, OP_SUB, OP_NOR,
          OP_MOVR, OP_MOVA, OP_JZR, OP_JCR: state_d = S_EXEC;
          OP_JZI, OP_JCI:                   state_d = S_IMM;
          OP_HALT: begin
            retire_s = 1'b1;
            state_d  = S_HALT;
          end
          default: begin
            Illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end

      S_EXEC: begin
        retire_s = 1'b1;
        state_d  = S_FETCH;
        case (op_s)
          OP_ADD: begin
            SelALU  = ALU_ADD;
            SelAcc  = ACC_ALU;
            LoadAcc = 1'b1;
          end
          OP_SUB: begin
            SelALU  = ALU_SUB;
            SelAcc  = ACC_ALU;
            LoadAcc = 1'b1;
          end
          OP_NOR: begin
            SelALU  = ALU_NOR;
            SelAcc  = ACC_ALU;
            LoadAcc = 1'b1;
          end
          OP_MOVR: begin
            SelALU  = ALU_PASS;
            SelAcc  = ACC_ALU;
            LoadAcc = 1'b1;
          end
          OP_MOVA: begin
            LoadReg = 1'b1;
          end
          OP_JZR: begin
            if (Z) begin
              LoadPC = 1'b1;
            end else begin
              LoadPC = 1'b0;
            end
          end
          OP_JCR: begin
            if (C) begin
              LoadPC = 1'b1;
            end else begin
              LoadPC = 1'b0;
            end
          end
          default: begin
            LoadPC = 1'b0;
          end
        endcase
      end

      S_IMM: begin
        // The immediate byte is consumed either way: jump to it or step over it.
        MemReq = 1'b1;
        if (MemAck) begin
          retire_s = 1'b1;
          state_d  = S_FETCH;
          if (imm_flag_s) begin
            LoadPC = 1'b1;
            SelPC  = 1'b1;
          end else begin
            IncPC  = 1'b1;
          end
        end else begin
          state_d = S_IMM;
        end
      end

      S_HALT: begin
        Halted  = 1'b1;
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_comb begin
    if (retire_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Directed-vector bench for fetch_exec_sequencer: one table row per clock cycle,
// plus hand sequences for reset during an immediate wait and counter wrap.
module tb_fetch_exec_sequencer;

  logic        CLK = 1'b0;
  logic        CLB = 1'b0;
  logic [7:0]  Opcode = 8'h00;
  logic        Z = 1'b0;
  logic        C = 1'b0;
  logic        MemAck = 1'b0;
  logic        MemReq, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, Halted, Illegal;
  logic [1:0]  SelAcc;
  logic [3:0]  SelALU;
  logic [15:0] InstrCount;
  logic [14:0] o2_unused;
  logic [1:0]  cnt2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  fetch_exec_sequencer #(.CNT_W(16)) dut (
    .CLK(CLK), .CLB(CLB), .Opcode(Opcode), .Z(Z), .C(C), .MemAck(MemAck),
    .MemReq(MemReq), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
    .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc), .SelALU(SelALU),
    .Halted(Halted), .Illegal(Illegal), .InstrCount(InstrCount)
  );

  fetch_exec_sequencer #(.CNT_W(2)) dut2 (
    .CLK(CLK), .CLB(CLB), .Opcode(Opcode), .Z(Z), .C(C), .MemAck(MemAck),
    .MemReq(o2_unused[14]), .LoadIR(o2_unused[13]), .IncPC(o2_unused[12]),
    .SelPC(o2_unused[11]), .LoadPC(o2_unused[10]), .LoadReg(o2_unused[9]),
    .LoadAcc(o2_unused[8]), .SelAcc(o2_unused[7:6]), .SelALU(o2_unused[5:2]),
    .Halted(o2_unused[1]), .Illegal(o2_unused[0]), .InstrCount(cnt2)
  );

  // Packed output layout: {MemReq,LoadIR,IncPC,SelPC,LoadPC,LoadReg,LoadAcc,SelAcc,SelALU,Halted,Illegal}
  localparam logic [14:0] N      = 15'h0000;
  localparam logic [14:0] MREQ   = 15'h4000;
  localparam logic [14:0] LIR    = 15'h2000;
  localparam logic [14:0] INC    = 15'h1000;
  localparam logic [14:0] SPC    = 15'h0800;
  localparam logic [14:0] LPC    = 15'h0400;
  localparam logic [14:0] LREG   = 15'h0200;
  localparam logic [14:0] LACC   = 15'h0100;
  localparam logic [14:0] ACCALU = 15'h0080;
  localparam logic [14:0] A_ADD  = 15'h0008;
  localparam logic [14:0] A_SUB  = 15'h000C;
  localparam logic [14:0] A_NOR  = 15'h0010;
  localparam logic [14:0] HLT    = 15'h0002;
  localparam logic [14:0] ILL    = 15'h0001;
  localparam logic [14:0] FA     = MREQ | LIR | INC;

  typedef struct {
    logic        clb;
    logic [7:0]  op;
    logic        z;
    logic        c;
    logic        ack;
    logic [14:0] exp_o;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic clb, logic [7:0] op, logic z, logic c, logic ack,
                              logic [14:0] exp_o, logic [15:0] exp_cnt);
    vec_t t;
    t.clb = clb; t.op = op; t.z = z; t.c = c; t.ack = ack;
    t.exp_o = exp_o; t.exp_cnt = exp_cnt;
    return t;
  endfunction

  function automatic logic [14:0] outs();
    return {MemReq, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU, Halted, Illegal};
  endfunction

  task automatic check(string name, logic [14:0] exp_o, logic [15:0] exp_cnt);
    logic [14:0] got;
    got = outs();
    n_vec++;
    if (got !== exp_o || InstrCount !== exp_cnt) begin
      n_bad++;
      $display("FAIL %s: outputs=%h count=%0d, expected outputs=%h count=%0d",
               name, got, InstrCount, exp_o, exp_cnt);
    end
  endtask

  initial begin
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, N, 16'd0));
    tbl.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, N, 16'd0));
    // ADD, zero-wait
    tbl.push_back(mk(1'b1, 8'h13, 1'b0, 1'b0, 1'b1, FA, 16'd0));
    tbl.push_back(mk(1'b1, 8'h13, 1'b0, 1'b0, 1'b1, N, 16'd0));
    tbl.push_back(mk(1'b1, 8'h13, 1'b0, 1'b0, 1'b1, A_ADD | ACCALU | LACC, 16'd0));
    // SUB with three fetch wait cycles
    tbl.push_back(mk(1'b1, 8'h25, 1'b0, 1'b0, 1'b0, MREQ, 16'd1));
    tbl.push_back(mk(1'b1, 8'h25, 1'b0, 1'b0, 1'b0, MREQ, 16'd1));
    tbl.push_back(mk(1'b1, 8'h25, 1'b0, 1'b0, 1'b0, MREQ, 16'd1));
    tbl.push_back(mk(1'b1, 8'h25, 1'b0, 1'b0, 1'b1, FA, 16'd1));
    tbl.push_back(mk(1'b1, 8'h25, 1'b0, 1'b0, 1'b1, N, 16'd1));
    tbl.push_back(mk(1'b1, 8'h25, 1'b0, 1'b0, 1'b1, A_SUB | ACCALU | LACC, 16'd1));
    // NOR, MOVR, MOVA
    tbl.push_back(mk(1'b1, 8'h31, 1'b0, 1'b0, 1'b1, FA, 16'd2));
    tbl.push_back(mk(1'b1, 8'h31, 1'b0, 1'b0, 1'b1, N, 16'd2));
    tbl.push_back(mk(1'b1, 8'h31, 1'b0, 1'b0, 1'b1, A_NOR | ACCALU | LACC, 16'd2));
    tbl.push_back(mk(1'b1, 8'h42, 1'b0, 1'b0, 1'b1, FA, 16'd3));
    tbl.push_back(mk(1'b1, 8'h42, 1'b0, 1'b0, 1'b1, N, 16'd3));
    tbl.push_back(mk(1'b1, 8'h42, 1'b0, 1'b0, 1'b1, ACCALU | LACC, 16'd3));
    tbl.push_back(mk(1'b1, 8'h57, 1'b0, 1'b0, 1'b1, FA, 16'd4));
    tbl.push_back(mk(1'b1, 8'h57, 1'b0, 1'b0, 1'b1, N, 16'd4));
    tbl.push_back(mk(1'b1, 8'h57, 1'b0, 1'b0, 1'b1, LREG, 16'd4));
    // JZI taken, then not taken with one immediate wait (C set to catch wrong flag)
    tbl.push_back(mk(1'b1, 8'h70, 1'b1, 1'b0, 1'b1, FA, 16'd5));
    tbl.push_back(mk(1'b1, 8'h70, 1'b1, 1'b0, 1'b1, N, 16'd5));
    tbl.push_back(mk(1'b1, 8'h70, 1'b1, 1'b0, 1'b1, MREQ | LPC | SPC, 16'd5));
    tbl.push_back(mk(1'b1, 8'h70, 1'b0, 1'b1, 1'b1, FA, 16'd6));
    tbl.push_back(mk(1'b1, 8'h70, 1'b0, 1'b1, 1'b1, N, 16'd6));
    tbl.push_back(mk(1'b1, 8'h70, 1'b0, 1'b1, 1'b0, MREQ, 16'd6));
    tbl.push_back(mk(1'b1, 8'h70, 1'b0, 1'b1, 1'b1, MREQ | INC, 16'd6));
    // JCR not taken (Z set), then taken with C low at decode and high at execute
    tbl.push_back(mk(1'b1, 8'h82, 1'b1, 1'b0, 1'b1, FA, 16'd7));
    tbl.push_back(mk(1'b1, 8'h82, 1'b1, 1'b0, 1'b1, N, 16'd7));
    tbl.push_back(mk(1'b1, 8'h82, 1'b1, 1'b0, 1'b1, N, 16'd7));
    tbl.push_back(mk(1'b1, 8'h82, 1'b0, 1'b0, 1'b1, FA, 16'd8));
    tbl.push_back(mk(1'b1, 8'h82, 1'b0, 1'b0, 1'b1, N, 16'd8));
    tbl.push_back(mk(1'b1, 8'h82, 1'b0, 1'b1, 1'b1, LPC, 16'd8));
    // JZR taken, JCI taken, NOP with flags set
    tbl.push_back(mk(1'b1, 8'h60, 1'b1, 1'b0, 1'b1, FA, 16'd9));
    tbl.push_back(mk(1'b1, 8'h60, 1'b1, 1'b0, 1'b1, N, 16'd9));
    tbl.push_back(mk(1'b1, 8'h60, 1'b1, 1'b0, 1'b1, LPC, 16'd9));
    tbl.push_back(mk(1'b1, 8'h90, 1'b0, 1'b1, 1'b1, FA, 16'd10));
    tbl.push_back(mk(1'b1, 8'h90, 1'b0, 1'b1, 1'b1, N, 16'd10));
    tbl.push_back(mk(1'b1, 8'h90, 1'b0, 1'b1, 1'b1, MREQ | LPC | SPC, 16'd10));
    tbl.push_back(mk(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, FA, 16'd11));
    tbl.push_back(mk(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, N, 16'd11));
    tbl.push_back(mk(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, N, 16'd11));
    // Illegal opcode, then HALT
    tbl.push_back(mk(1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, FA, 16'd12));
    tbl.push_back(mk(1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, ILL, 16'd12));
    tbl.push_back(mk(1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, FA, 16'd12));
    tbl.push_back(mk(1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, N, 16'd12));
    tbl.push_back(mk(1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, HLT, 16'd13));
    tbl.push_back(mk(1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, HLT, 16'd13));
    tbl.push_back(mk(1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, HLT, 16'd13));

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge CLK);
      #1;
      CLB = tbl[i].clb; Opcode = tbl[i].op; Z = tbl[i].z; C = tbl[i].c; MemAck = tbl[i].ack;
      #1;
      check($sformatf("vec%0d", i), tbl[i].exp_o, tbl[i].exp_cnt);
    end

    // Leave HALT via reset, then assert reset while waiting on an immediate byte
    @(posedge CLK); #1; CLB = 1'b0; #1;
    check("halt_reset", N, 16'd0);
    @(posedge CLK); #1; CLB = 1'b1; Opcode = 8'h70; MemAck = 1'b1; Z = 1'b1; C = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1; MemAck = 1'b0; #1;
    check("imm_wait", MREQ, 16'd0);
    #1; CLB = 1'b0; #1;
    check("imm_wait_reset", N, 16'd0);
    @(posedge CLK); #1;
    check("imm_reset_held", N, 16'd0);

    // Five NOPs on a 2-bit counter: 1,2,3,0,1
    CLB = 1'b1; Opcode = 8'h00; MemAck = 1'b1; Z = 1'b0;
    @(posedge CLK);
    for (int k = 0; k < 5; k++) begin
      logic [1:0] wrap_exp;
      wrap_exp = 2'(k + 1);
      repeat (3) @(posedge CLK);
      #2;
      n_vec++;
      if (cnt2 !== wrap_exp || InstrCount !== 16'(k + 1)) begin
        n_bad++;
        $display("FAIL nop_wrap%0d: count2=%0d count16=%0d, expected count2=%0d count16=%0d",
                 k, cnt2, InstrCount, wrap_exp, k + 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
